// File: rtl/lbus_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lbus_bridge_pkg
//  Purpose  : Shared definitions for the local-bus burst bridge. Holds the
//             register offsets relative to REG_BASE, the CTRL and STATUS bit
//             positions, and the bus FSM state encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package lbus_bridge_pkg;

  // Register offsets from REG_BASE
  localparam logic [5:0] C_OFF_LADDR  = 6'd0;
  localparam logic [5:0] C_OFF_WBUF   = 6'd1;
  localparam logic [5:0] C_OFF_RBUF   = 6'd2;
  localparam logic [5:0] C_OFF_CTRL   = 6'd3;
  localparam logic [5:0] C_OFF_STATUS = 6'd4;

  // CTRL byte fields
  localparam int C_CTRL_N_MSB = 4;
  localparam int C_CTRL_DIR   = 5;
  localparam int C_CTRL_INC   = 6;
  localparam int C_CTRL_RST   = 7;

  // STATUS byte fields
  localparam int C_STAT_BUSY  = 0;
  localparam int C_STAT_DONE  = 1;
  localparam int C_STAT_OVF   = 2;
  localparam int C_STAT_CLAMP = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RSTP  = 3'd1,
    ST_WADDR = 3'd2,
    ST_WDATA = 3'd3,
    ST_RADDR = 3'd4,
    ST_RSTB  = 3'd5,
    ST_GAP   = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

endpackage
`default_nettype wire

// File: rtl/lbus_word_buf.sv
`default_nettype none
// ============================================================================
//  Module   : lbus_word_buf
//  Purpose  : DEPTH x LBUS_W word store with a byte-lane write port for the
//             register side, a word write port for the bus FSM and an
//             asynchronous word read port. Cleared by reset.
//  Ports    : clk, reset_i        - clock, synchronous active-high reset
//             be_en/word/lane/data - byte-lane write
//             we_en/word/data     - full-word write (wins over byte write)
//             rd_word -> rd_data  - combinational word read
//  Revision : 1.0 - initial release
// ============================================================================
module lbus_word_buf #(
  parameter int LBUS_W = 16,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4,
  parameter int LANE_W = 1
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              be_en,
  input  logic [IDX_W-1:0]  be_word,
  input  logic [LANE_W-1:0] be_lane,
  input  logic [7:0]        be_data,
  input  logic              we_en,
  input  logic [IDX_W-1:0]  we_word,
  input  logic [LBUS_W-1:0] we_data,
  input  logic [IDX_W-1:0]  rd_word,
  output logic [LBUS_W-1:0] rd_data
);

  localparam int BPW = LBUS_W / 8;

  logic [LBUS_W-1:0] mem_q [DEPTH];
  logic [LBUS_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (be_en) begin
      for (int l = 0; l < BPW; l++) begin
        if (be_lane == LANE_W'(l)) mem_d[be_word][8*l +: 8] = be_data;
      end
    end
    if (we_en) mem_d[we_word] = we_data;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_word];

endmodule
`default_nettype wire

// File: rtl/lbus_burst_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : lbus_burst_bridge
//  Purpose  : OpenADC register interface to controller/crypto-FPGA local bus
//             bridge with buffered bursts, address auto-increment, strobe and
//             gap timing and a timed bus-reset pulse.
//  Ports    : clk, reset_i         - clock, synchronous active-high reset
//             reg_*                - OpenADC register interface (8-bit)
//             lbus_di_a / lbus_do  - local-bus address+wdata out / rdata in
//             lbus_wrn / lbus_rdn  - active-low write / read strobes
//             lbus_clkn, lbus_rstn - inverted bus clock, active-low bus reset
//  Revision : 1.0 - initial release
// ============================================================================
module lbus_burst_bridge
  import lbus_bridge_pkg::*;
#(
  parameter int         LBUS_W   = 16,
  parameter int         DEPTH    = 16,
  parameter logic [5:0] REG_BASE = 6'd48,
  parameter int         RD_WAIT  = 2,
  parameter int         GAP_CYC  = 1,
  parameter int         RST_CYC  = 8
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic [5:0]        reg_address,
  input  logic [15:0]       reg_bytecnt,
  input  logic [7:0]        reg_datai,
  output logic [7:0]        reg_datao,
  input  logic [15:0]       reg_size,
  input  logic              reg_read,
  input  logic              reg_write,
  input  logic              reg_addrvalid,
  input  logic [5:0]        reg_hypaddress,
  output logic [15:0]       reg_hyplen,
  output logic [LBUS_W-1:0] lbus_di_a,
  input  logic [LBUS_W-1:0] lbus_do,
  output logic              lbus_wrn,
  output logic              lbus_rdn,
  output logic              lbus_clkn,
  output logic              lbus_rstn
);

  localparam int BPW    = LBUS_W / 8;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int CNT_W  = (IDX_W + 1 > 5) ? IDX_W + 1 : 5;

  localparam logic [15:0]       C_BPW16     = 16'(BPW);
  localparam logic [15:0]       C_NBYTES    = 16'(DEPTH * BPW);
  localparam logic [CNT_W-1:0]  C_DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [LBUS_W-1:0] C_ADDR_STEP = LBUS_W'(BPW);
  localparam logic [15:0]       C_RST_LAST  = 16'(RST_CYC - 1);
  localparam logic [15:0]       C_RD_LAST   = 16'(RD_WAIT - 1);
  localparam logic [15:0]       C_GAP_LAST  = 16'(GAP_CYC - 1);

  localparam logic [5:0] C_A_LADDR  = REG_BASE + C_OFF_LADDR;
  localparam logic [5:0] C_A_WBUF   = REG_BASE + C_OFF_WBUF;
  localparam logic [5:0] C_A_RBUF   = REG_BASE + C_OFF_RBUF;
  localparam logic [5:0] C_A_CTRL   = REG_BASE + C_OFF_CTRL;
  localparam logic [5:0] C_A_STATUS = REG_BASE + C_OFF_STATUS;

  state_e            state_q, state_d;
  logic [15:0]       tmr_q, tmr_d;
  logic [CNT_W-1:0]  idx_q, idx_d, n_q, n_d;
  logic [LBUS_W-1:0] cur_addr_q, cur_addr_d, laddr_q, laddr_d, di_hold_q, di_hold_d;
  logic              dir_q, dir_d, inc_q, inc_d;
  logic              busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, clamp_q, clamp_d;

  // Register-side byte decode
  logic [15:0]       w_word16, w_lane16;
  logic [IDX_W-1:0]  w_word;
  logic [LANE_W-1:0] w_lane;
  logic              w_bidx_ok, w_lane_ok, w_wbuf_wr, w_go, w_word_end, w_advance;
  logic [CNT_W-1:0]  w_n_req, w_idx_nxt;
  logic [LBUS_W-1:0] w_wbuf_word, w_rbuf_word;
  logic [7:0]        w_status;
  logic              w_unused;

  assign w_word16  = reg_bytecnt / C_BPW16;
  assign w_lane16  = reg_bytecnt % C_BPW16;
  assign w_word    = w_word16[IDX_W-1:0];
  assign w_lane    = w_lane16[LANE_W-1:0];
  assign w_bidx_ok = (reg_bytecnt < C_NBYTES);
  assign w_lane_ok = (reg_bytecnt < C_BPW16);
  assign w_unused  = ^{reg_size, reg_read, w_word16[15:IDX_W], w_lane16[15:LANE_W]};

  assign w_wbuf_wr = reg_addrvalid && reg_write && (reg_address == C_A_WBUF) && w_bidx_ok;
  assign w_go      = reg_addrvalid && reg_write && (reg_address == C_A_CTRL) &&
                     (reg_datai[C_CTRL_RST] || (reg_datai[C_CTRL_N_MSB:0] != '0)) &&
                     (state_q == ST_IDLE);
  assign w_n_req   = CNT_W'(reg_datai[C_CTRL_N_MSB:0]);
  assign w_idx_nxt = idx_q + CNT_W'(1);

  lbus_word_buf #(.LBUS_W(LBUS_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .LANE_W(LANE_W)) u_wbuf (
    .clk     (clk),
    .reset_i (reset_i),
    .be_en   (w_wbuf_wr),
    .be_word (w_word),
    .be_lane (w_lane),
    .be_data (reg_datai),
    .we_en   (1'b0),
    .we_word ('0),
    .we_data ('0),
    .rd_word (idx_q[IDX_W-1:0]),
    .rd_data (w_wbuf_word)
  );

  // Read data is captured on the final cycle of the read strobe.
  lbus_word_buf #(.LBUS_W(LBUS_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .LANE_W(LANE_W)) u_rbuf (
    .clk     (clk),
    .reset_i (reset_i),
    .be_en   (1'b0),
    .be_word ('0),
    .be_lane ('0),
    .be_data ('0),
    .we_en   ((state_q == ST_RSTB) && (tmr_q == C_RD_LAST)),
    .we_word (idx_q[IDX_W-1:0]),
    .we_data (lbus_do),
    .rd_word (w_word),
    .rd_data (w_rbuf_word)
  );

  // LADDR writes and overflow flag; LADDR stays writable during a burst
  // because the active address was copied into cur_addr at go time.
  // ovf is sticky until reset.
  always_comb begin
    laddr_d = laddr_q;
    ovf_d   = ovf_q;
    if (reg_addrvalid && reg_write && (reg_address == C_A_LADDR) && w_lane_ok) begin
      for (int l = 0; l < BPW; l++) begin
        if (w_lane == LANE_W'(l)) laddr_d[8*l +: 8] = reg_datai;
      end
    end
    if (reg_addrvalid && reg_write && (reg_address == C_A_WBUF) && !w_bidx_ok) ovf_d = 1'b1;
  end

  // Bus FSM next state
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    idx_d      = idx_q;
    n_d        = n_q;
    cur_addr_d = cur_addr_q;
    dir_d      = dir_q;
    inc_d      = inc_q;
    busy_d     = busy_q;
    done_d     = done_q;
    clamp_d    = clamp_q;
    w_word_end = 1'b0;
    w_advance  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (w_go) begin
          // clamp reflects the most recent accepted go
          if (w_n_req > C_DEPTH_CNT) begin
            n_d     = C_DEPTH_CNT;
            clamp_d = 1'b1;
          end else begin
            n_d     = w_n_req;
            clamp_d = 1'b0;
          end
          dir_d      = reg_datai[C_CTRL_DIR];
          inc_d      = reg_datai[C_CTRL_INC];
          cur_addr_d = laddr_q;
          idx_d      = '0;
          tmr_d      = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          if (reg_datai[C_CTRL_RST])     state_d = ST_RSTP;
          else if (reg_datai[C_CTRL_DIR]) state_d = ST_RADDR;
          else                           state_d = ST_WADDR;
        end
      end
      ST_RSTP: begin
        if (tmr_q == C_RST_LAST) begin
          tmr_d = '0;
          if (n_q == '0)  state_d = ST_DONE;
          else if (dir_q) state_d = ST_RADDR;
          else            state_d = ST_WADDR;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      ST_WADDR: state_d = ST_WDATA;
      ST_WDATA: w_word_end = 1'b1;
      ST_RADDR: state_d = ST_RSTB;
      ST_RSTB: begin
        if (tmr_q == C_RD_LAST) begin
          tmr_d      = '0;
          w_word_end = 1'b1;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      ST_GAP: begin
        if (tmr_q == C_GAP_LAST) begin
          tmr_d     = '0;
          w_advance = 1'b1;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A zero-length gap folds the word advance into the last strobe cycle.
    if (w_word_end) begin
      if (GAP_CYC == 0) w_advance = 1'b1;
      else              state_d   = ST_GAP;
    end
    if (w_advance) begin
      idx_d = w_idx_nxt;
      if (inc_q) cur_addr_d = cur_addr_q + C_ADDR_STEP;
      if (w_idx_nxt < n_q) state_d = dir_q ? ST_RADDR : ST_WADDR;
      else                 state_d = ST_DONE;
    end
  end

  // Bus outputs decode straight from the state register.
  always_comb begin
    lbus_wrn  = 1'b1;
    lbus_rdn  = 1'b1;
    lbus_rstn = 1'b1;
    lbus_di_a = di_hold_q;
    unique case (state_q)
      ST_WADDR, ST_RADDR: begin
        lbus_wrn  = 1'b0;
        lbus_di_a = cur_addr_q;
      end
      ST_WDATA: begin
        lbus_wrn  = 1'b0;
        lbus_di_a = w_wbuf_word;
      end
      ST_RSTB: lbus_rdn  = 1'b0;
      ST_RSTP: lbus_rstn = 1'b0;
      default: ;
    endcase
  end

  assign di_hold_d = lbus_di_a;
  assign lbus_clkn = ~clk;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      idx_q      <= '0;
      n_q        <= '0;
      cur_addr_q <= '0;
      laddr_q    <= '0;
      di_hold_q  <= '0;
      dir_q      <= 1'b0;
      inc_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      clamp_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      cur_addr_q <= cur_addr_d;
      laddr_q    <= laddr_d;
      di_hold_q  <= di_hold_d;
      dir_q      <= dir_d;
      inc_q      <= inc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      clamp_q    <= clamp_d;
    end
  end

  // Register read mux and lookahead lengths
  always_comb begin
    w_status               = 8'h00;
    w_status[C_STAT_BUSY]  = busy_q;
    w_status[C_STAT_DONE]  = done_q;
    w_status[C_STAT_OVF]   = ovf_q;
    w_status[C_STAT_CLAMP] = clamp_q;
  end

  always_comb begin
    reg_datao = 8'h00;
    if (reg_addrvalid) begin
      if ((reg_address == C_A_LADDR) && w_lane_ok) begin
        for (int l = 0; l < BPW; l++) begin
          if (w_lane == LANE_W'(l)) reg_datao = laddr_q[8*l +: 8];
        end
      end else if ((reg_address == C_A_RBUF) && w_bidx_ok) begin
        for (int l = 0; l < BPW; l++) begin
          if (w_lane == LANE_W'(l)) reg_datao = w_rbuf_word[8*l +: 8];
        end
      end else if ((reg_address == C_A_STATUS) && (reg_bytecnt == 16'd0)) begin
        reg_datao = w_status;
      end
    end
  end

  always_comb begin
    reg_hyplen = 16'd0;
    if (reg_hypaddress == C_A_LADDR)                                 reg_hyplen = C_BPW16;
    else if ((reg_hypaddress == C_A_WBUF) || (reg_hypaddress == C_A_RBUF))   reg_hyplen = C_NBYTES;
    else if ((reg_hypaddress == C_A_CTRL) || (reg_hypaddress == C_A_STATUS)) reg_hyplen = 16'd1;
  end

endmodule
`default_nettype wire

// File: tb/tb_lbus_burst_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lbus_burst_bridge
//  Purpose  : Directed self-checking bench for lbus_burst_bridge. Expected
//             bus words are queued as bursts are launched and matched as the
//             bus monitor assembles them.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lbus_burst_bridge;

  localparam logic [5:0] A_LADDR  = 6'd48;
  localparam logic [5:0] A_WBUF   = 6'd49;
  localparam logic [5:0] A_RBUF   = 6'd50;
  localparam logic [5:0] A_CTRL   = 6'd51;
  localparam logic [5:0] A_STATUS = 6'd52;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [5:0]  reg_address;
  logic [15:0] reg_bytecnt;
  logic [7:0]  reg_datai;
  logic [7:0]  reg_datao;
  logic [15:0] reg_size;
  logic        reg_read;
  logic        reg_write;
  logic        reg_addrvalid;
  logic [5:0]  reg_hypaddress;
  logic [15:0] reg_hyplen;
  logic [15:0] lbus_di_a;
  logic [15:0] lbus_do;
  logic        lbus_wrn, lbus_rdn, lbus_clkn, lbus_rstn;

  lbus_burst_bridge dut (
    .clk            (clk),
    .reset_i        (reset_i),
    .reg_address    (reg_address),
    .reg_bytecnt    (reg_bytecnt),
    .reg_datai      (reg_datai),
    .reg_datao      (reg_datao),
    .reg_size       (reg_size),
    .reg_read       (reg_read),
    .reg_write      (reg_write),
    .reg_addrvalid  (reg_addrvalid),
    .reg_hypaddress (reg_hypaddress),
    .reg_hyplen     (reg_hyplen),
    .lbus_di_a      (lbus_di_a),
    .lbus_do        (lbus_do),
    .lbus_wrn       (lbus_wrn),
    .lbus_rdn       (lbus_rdn),
    .lbus_clkn      (lbus_clkn),
    .lbus_rstn      (lbus_rstn)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic [15:0] addr;
    logic [15:0] data;
    logic [3:0]  low;
  } word_t;

  word_t       exp_q[$];
  logic [15:0] do_q[$];
  logic [15:0] wmodel [16];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_word(input word_t got);
    word_t exp;
    chk("sb_word_was_expected", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      chk("sb_word{rd,addr,data,low}", 64'(got), 64'(exp));
    end
  endtask

  // Bus monitor and read-data responder
  logic        m_prev_wrn = 1'b1, m_prev_rdn = 1'b1;
  int          m_wlow = 0, m_rlow = 0;
  logic [15:0] m_addr = '0, m_data = '0;

  always @(negedge clk) begin
    if (!lbus_wrn) begin
      if (m_prev_wrn) begin m_addr = lbus_di_a; m_wlow = 1; end
      else begin m_data = lbus_di_a; m_wlow++; end
    end else if (!m_prev_wrn && lbus_rdn) begin
      compare_word('{rd: 1'b0, addr: m_addr, data: m_data, low: 4'(m_wlow)});
    end
    if (!lbus_rdn) begin
      if (m_prev_rdn) begin
        m_rlow = 1;
        if (do_q.size() != 0) lbus_do = do_q.pop_front();
      end else begin
        m_rlow++;
      end
    end else if (!m_prev_rdn) begin
      compare_word('{rd: 1'b1, addr: m_addr, data: 16'h0, low: 4'(m_rlow)});
    end
    m_prev_wrn = lbus_wrn;
    m_prev_rdn = lbus_rdn;
  end

  task automatic reg_wr(input logic [5:0] a, input logic [15:0] bc, input logic [7:0] d);
    @(negedge clk);
    reg_address = a; reg_bytecnt = bc; reg_datai = d;
    reg_addrvalid = 1'b1; reg_write = 1'b1;
    @(negedge clk);
    reg_write = 1'b0; reg_addrvalid = 1'b0;
  endtask

  task automatic rd_now(input logic [5:0] a, input logic [15:0] bc, output logic [7:0] d);
    reg_address = a; reg_bytecnt = bc; reg_addrvalid = 1'b1; reg_read = 1'b1;
    #1;
    d = reg_datao;
    reg_addrvalid = 1'b0; reg_read = 1'b0;
  endtask

  task automatic set_laddr(input logic [15:0] a);
    reg_wr(A_LADDR, 16'd0, a[7:0]);
    reg_wr(A_LADDR, 16'd1, a[15:8]);
  endtask

  task automatic wr_word(input int i, input logic [15:0] v);
    reg_wr(A_WBUF, 16'(2*i), v[7:0]);
    reg_wr(A_WBUF, 16'(2*i+1), v[15:8]);
    wmodel[i] = v;
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [15:0] d);
    exp_q.push_back('{rd: 1'b0, addr: a, data: d, low: 4'd2});
  endtask

  task automatic push_rd(input logic [15:0] a);
    exp_q.push_back('{rd: 1'b1, addr: a, data: 16'h0, low: 4'd2});
  endtask

  task automatic wait_done(input string tag);
    logic [7:0] s;
    logic       ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rd_now(A_STATUS, 16'd0, s);
      if (s[1] && !s[0]) begin ok = 1'b1; break; end
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  initial begin
    logic [7:0] b;
    logic       found;
    int         rst_low, strobes;

    reset_i = 1'b1; reg_address = '0; reg_bytecnt = '0; reg_datai = '0;
    reg_size = '0; reg_read = 1'b0; reg_write = 1'b0; reg_addrvalid = 1'b0;
    reg_hypaddress = '0; lbus_do = '0;
    for (int i = 0; i < 16; i++) wmodel[i] = 16'h0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_wrn", 64'(lbus_wrn), 64'd1);
    chk("rst_rdn", 64'(lbus_rdn), 64'd1);
    chk("rst_rstn", 64'(lbus_rstn), 64'd1);
    chk("rst_di_a", 64'(lbus_di_a), 64'd0);
    reset_i = 1'b0;
    rd_now(A_STATUS, 16'd0, b); chk("rst_status", 64'(b), 64'h00);

    // Lookahead lengths
    reg_hypaddress = A_LADDR;  #1 chk("hyplen_laddr", 64'(reg_hyplen), 64'd2);
    reg_hypaddress = A_RBUF;   #1 chk("hyplen_rbuf", 64'(reg_hyplen), 64'd32);
    reg_hypaddress = A_STATUS; #1 chk("hyplen_status", 64'(reg_hyplen), 64'd1);
    reg_hypaddress = 6'd53;    #1 chk("hyplen_other", 64'(reg_hyplen), 64'd0);

    // Reset in the middle of a read burst
    set_laddr(16'h0010);
    rd_now(A_LADDR, 16'd0, b); chk("laddr_rb_b0", 64'(b), 64'h10);
    do_q.push_back(16'h1234);
    push_rd(16'h0010);
    reg_wr(A_CTRL, 16'd0, 8'h24);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!lbus_rdn) begin found = 1'b1; break; end
      @(negedge clk);
    end
    chk("midrst_rdn_seen", 64'(found), 64'd1);
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    chk("midrst_rdn", 64'(lbus_rdn), 64'd1);
    chk("midrst_wrn", 64'(lbus_wrn), 64'd1);
    chk("midrst_rstn", 64'(lbus_rstn), 64'd1);
    rd_now(A_STATUS, 16'd0, b); chk("midrst_status", 64'(b), 64'h00);
    rd_now(A_RBUF, 16'd0, b);   chk("midrst_rbuf0", 64'(b), 64'h00);

    // Write burst with auto-increment
    set_laddr(16'h0100);
    wr_word(0, 16'h1111); wr_word(1, 16'h2222); wr_word(2, 16'h3333);
    push_wr(16'h0100, 16'h1111); push_wr(16'h0102, 16'h2222); push_wr(16'h0104, 16'h3333);
    reg_wr(A_CTRL, 16'd0, 8'h43);
    repeat (8) @(negedge clk);
    rd_now(A_STATUS, 16'd0, b); chk("wr_status_busy", 64'(b), 64'h01);
    repeat (2) @(negedge clk);
    rd_now(A_STATUS, 16'd0, b); chk("wr_status_done", 64'(b), 64'h02);

    // Read burst without increment
    set_laddr(16'h0002);
    do_q.push_back(16'hBEEF); do_q.push_back(16'hCAFE);
    push_rd(16'h0002); push_rd(16'h0002);
    reg_wr(A_CTRL, 16'd0, 8'h22);
    wait_done("rd_done_wait");
    rd_now(A_RBUF, 16'd0, b);  chk("rbuf_b0", 64'(b), 64'hEF);
    rd_now(A_RBUF, 16'd1, b);  chk("rbuf_b1", 64'(b), 64'hBE);
    rd_now(A_RBUF, 16'd2, b);  chk("rbuf_b2", 64'(b), 64'hFE);
    rd_now(A_RBUF, 16'd3, b);  chk("rbuf_b3", 64'(b), 64'hCA);
    rd_now(A_RBUF, 16'd32, b); chk("rbuf_oob", 64'(b), 64'h00);

    // Bus reset pulse
    reg_wr(A_CTRL, 16'd0, 8'h80);
    rst_low = 0; strobes = 0;
    for (int i = 0; i < 30; i++) begin
      if (!lbus_rstn) rst_low++;
      if (!lbus_wrn || !lbus_rdn) strobes++;
      @(negedge clk);
    end
    chk("busrst_low_cycles", 64'(rst_low), 64'd8);
    chk("busrst_strobes", 64'(strobes), 64'd0);
    rd_now(A_STATUS, 16'd0, b); chk("busrst_status", 64'(b), 64'h02);

    // Clamp: N=31 transfers DEPTH words
    wr_word(15, 16'hF00F);
    set_laddr(16'h1000);
    for (int i = 0; i < 16; i++) push_wr(16'h1000 + 16'(2*i), wmodel[i]);
    reg_wr(A_CTRL, 16'd0, 8'h5F);
    wait_done("clamp_done_wait");
    rd_now(A_STATUS, 16'd0, b); chk("clamp_status", 64'(b), 64'h0A);

    // Overflowing buffer write is dropped
    reg_wr(A_WBUF, 16'd32, 8'hAA);
    rd_now(A_STATUS, 16'd0, b); chk("ovf_status", 64'(b), 64'h0E);
    rd_now(A_WBUF, 16'd0, b);   chk("wbuf_reads_zero", 64'(b), 64'h00);

    // Go while busy is ignored
    set_laddr(16'h0200);
    for (int i = 0; i < 4; i++) push_wr(16'h0200 + 16'(2*i), wmodel[i]);
    reg_wr(A_CTRL, 16'd0, 8'h44);
    reg_wr(A_CTRL, 16'd0, 8'h42);
    reg_wr(A_CTRL, 16'd0, 8'h80);
    wait_done("busy_go_done_wait");
    rd_now(A_STATUS, 16'd0, b); chk("busy_go_status", 64'(b), 64'h06);

    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    chk("rdata_drained", 64'(do_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/lbus_burst_bridge.md
Name: lbus_burst_bridge

Overview:
- Parametrised successor to the single-word SAKURA-G local-bus register bridge; sits between the OpenADC register interface (`reg_*`, 8-bit, `usb_clk` domain) and the controller-to-crypto-FPGA local bus.
- Adds generic bus width, buffered bursts of up to DEPTH words, address auto-increment, programmable strobe and gap timing, and a timed bus-reset pulse.
- One instance per local bus, instantiated in the board top in place of the single-word bridge.

Parameters:
- LBUS_W, 16, local-bus address/data width; multiple of 8.
- DEPTH, 16, words in each of the write and read buffers; power of two.
- REG_BASE, 6'd48, register address of REG_LADDR; the block decodes REG_BASE..REG_BASE+4.
- RD_WAIT, 2, cycles `lbus_rdn` stays low per read word; must be at least 1.
- GAP_CYC, 1, idle cycles between words; may be 0.
- RST_CYC, 8, cycles `lbus_rstn` is held low on a reset command.

Ports:
- clk  in  1  register-interface clock; all logic runs on its rising edge.
- reset_i  in  1  synchronous active-high reset.
- reg_address  in  6  register address.
- reg_bytecnt  in  16  byte index within the register.
- reg_datai  in  8  write byte.
- reg_datao  out  8  read byte.
- reg_size  in  16  transfer size (unused).
- reg_read  in  1  read strobe.
- reg_write  in  1  write strobe.
- reg_addrvalid  in  1  address-valid qualifier.
- reg_hypaddress  in  6  lookahead address.
- reg_hyplen  out  16  length of the lookahead register.
- lbus_di_a  out  LBUS_W  address/write data to the crypto FPGA.
- lbus_do  in  LBUS_W  read data from the crypto FPGA.
- lbus_wrn  out  1  write strobe, active low.
- lbus_rdn  out  1  read strobe, active low.
- lbus_clkn  out  1  bus clock, equal to ~clk.
- lbus_rstn  out  1  bus reset, active low.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
  - Clock port is `clk`, reset port is `reset_i`.
  - Reset forces: `lbus_wrn`=1, `lbus_rdn`=1, `lbus_rstn`=1, `lbus_di_a`=0, state IDLE.
  - Reset also clears: count, flags, address register, and both buffers. `reg_datao` then reads 0.
- Derived constants: BPW = LBUS_W/8 bytes per word; buffer byte index b addresses word b/BPW, byte lane b%BPW, little-endian.
- Register map, all gated by `reg_addrvalid`:
  - REG_LADDR (+0), r/w, BPW bytes: start address.
  - REG_WBUF (+1), write-only, DEPTH*BPW bytes: write data. The byte at `reg_bytecnt` is stored on `reg_write`.
  - REG_RBUF (+2), read-only, DEPTH*BPW bytes: read data. Read via `reg_bytecnt`.
  - REG_CTRL (+3), write-only, 1 byte:
    - bits[4:0] = word count N.
    - bit5 = dir (1 = read).
    - bit6 = auto-increment.
    - bit7 = bus-reset pulse.
    - Writing with bits[4:0] nonzero, or with bit7 set, is a "go".
  - REG_STATUS (+4), read-only, 1 byte:
    - bit0 busy, bit1 done, bit2 ovf, bit3 clamp.
    - done is cleared by the next go.
- `reg_hyplen` by `reg_hypaddress`: +0 → BPW; +1/+2 → DEPTH*BPW; +3/+4 → 1; other addresses → 0.
- `reg_datao` is a combinational mux of `reg_address` and `reg_bytecnt`; it is 0 for undecoded addresses or an out-of-range `reg_bytecnt`.
- Boundary: a REG_WBUF write with `reg_bytecnt` ≥ DEPTH*BPW is dropped and sets ovf.
- Boundary: N > DEPTH is clamped to DEPTH and sets clamp.
- Boundary: go while busy is ignored entirely; the buffers and REG_LADDR are not protected while busy.
- FSM states: IDLE, RSTP, WADDR, WDATA, RADDR, RSTB, GAP, DONE.
- IDLE, on go:
  - bit7 set → RSTP, which takes priority over N.
  - Otherwise dir=0 → WADDR, dir=1 → RADDR. Also latch cur_addr = REG_LADDR and idx = 0.
- RSTP: `lbus_rstn`=0 for RST_CYC cycles. Then DONE if N=0, else proceed as the non-reset go.
- WADDR (1 cycle): `lbus_wrn`=0, `lbus_di_a`=cur_addr.
- WDATA (1 cycle): `lbus_wrn`=0, `lbus_di_a`=wbuf[idx].
- RADDR (1 cycle): `lbus_wrn`=0, `lbus_di_a`=cur_addr.
- RSTB: `lbus_rdn`=0 for RD_WAIT cycles. `lbus_do` is captured into rbuf[idx] on the last RSTB cycle.
- GAP: both strobes high for GAP_CYC cycles (skipped if 0). Then idx++; if auto-increment, cur_addr += BPW (wraps modulo 2^LBUS_W).
  - Next state: back to WADDR/RADDR if idx < N, else DONE.
- DONE: set done, clear busy, go to IDLE.
- busy is set from the go cycle until the DONE cycle.
- Per-word latency: write 2+GAP_CYC cycles; read 1+RD_WAIT+GAP_CYC cycles.
- `lbus_di_a` holds its last value when idle.

Decomposition:
- Package `lbus_bridge_pkg`:
  - register offsets;
  - CTRL bit positions;
  - STATUS bit positions;
  - FSM state enum.
- One sub-module, `lbus_word_buf`: DEPTH×LBUS_W storage.
  - Byte-lane write port for the register side.
  - Word read/write port for the FSM side.
  - Instantiated twice, once for wbuf and once for rbuf.

Test Plan:
- Reset mid-burst: read burst N=4 with reset_i asserted in the 2nd RSTB cycle → next cycle `lbus_rdn`=1, `lbus_wrn`=1, `lbus_rstn`=1; STATUS reads 0x00.
- Write burst: LADDR=0x0100, WBUF = 0x1111, 0x2222, 0x3333, CTRL=0x43 (N=3, auto-increment).
  - Bus shows (addr 0x0100, data 0x1111), (0x0102, 0x2222), (0x0104, 0x3333) with `lbus_wrn` low 2 cycles per word.
  - STATUS=0x02 after 9 cycles.
- Read, no increment: LADDR=0x0002, CTRL=0x22 (N=2), model drives `lbus_do`=0xBEEF then 0xCAFE.
  - Both address phases carry 0x0002; `lbus_rdn` low 2 cycles each.
  - RBUF bytes 0..3 = EF, BE, FE, CA.
- Bus reset: CTRL=0x80 → `lbus_rstn` low exactly 8 cycles, no strobes, STATUS done=1.
- Clamp and overflow:
  - CTRL N=31 → exactly 16 words transferred, clamp=1.
  - REG_WBUF write at `reg_bytecnt`=32 → ovf=1, buffer unchanged.
- Go while busy: second CTRL write during a 4-word write burst → exactly 4 words on the bus, N unchanged.
